// File: rtl/sid_bus_arbiter.sv
// SID register bus arbiter: one access slot per phi2 cycle, external 6502 bus
// first, host port gets every slot the external bus leaves idle.
module sid_bus_arbiter #(
   parameter int SETTLE_CLKS  = 6,
   parameter int STARVE_LIMIT = 255,
   parameter int NUM_CS       = 4,
   localparam int SEL_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
   localparam int CNT_W       = $clog2(SETTLE_CLKS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              phi2,
   input  logic [NUM_CS-1:0] ext_cs,
   input  logic              ext_we,
   input  logic [4:0]        ext_addr,
   input  logic [7:0]        ext_data,
   input  logic              host_valid,
   output logic              host_ready,
   input  logic [SEL_W-1:0]  host_sel,
   input  logic              host_we,
   input  logic [4:0]        host_addr,
   input  logic [7:0]        host_data,
   output logic [7:0]        host_rdata,
   output logic              host_rvalid,
   output logic              host_starved,
   output logic [NUM_CS-1:0] sid_cs,
   output logic              sid_we,
   output logic [4:0]        sid_addr,
   output logic [7:0]        sid_data,
   input  logic [7:0]        sid_rdata
);

   typedef enum logic [1:0] {WAIT_RISE, SETTLE, GRANT} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_EXT, OWN_HOST} owner_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CLKS - 1);
   localparam logic [7:0]       STARVE_MAX  = 8'(STARVE_LIMIT);

   state_t              state_q, state_d;
   owner_t              owner_q, owner_d;
   logic                phi2_q;
   logic [CNT_W-1:0]    settle_q, settle_d;
   logic [7:0]          starve_q, starve_d;
   logic [NUM_CS-1:0]   sid_cs_q, sid_cs_d;
   logic                sid_we_q, sid_we_d;
   logic [4:0]          sid_addr_q, sid_addr_d;
   logic [7:0]          sid_data_q, sid_data_d;
   logic                host_ready_q, host_ready_d;
   logic                host_rvalid_q, host_rvalid_d;
   logic [7:0]          host_rdata_q, host_rdata_d;
   logic                host_starved_q, host_starved_d;
   logic                rise, fall;

   assign rise = phi2 & ~phi2_q;
   assign fall = ~phi2 & phi2_q;

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      settle_d      = settle_q;
      starve_d      = starve_q;
      sid_cs_d      = sid_cs_q;
      sid_we_d      = sid_we_q;
      sid_addr_d    = sid_addr_q;
      sid_data_d    = sid_data_q;
      host_ready_d  = 1'b0;
      host_rvalid_d = 1'b0;
      host_rdata_d  = host_rdata_q;
      case (state_q)
         WAIT_RISE: begin
            if (rise) begin
               state_d  = SETTLE;
               settle_d = '0;
            end
         end
         SETTLE: begin
            // a short phi2 high phase gives up the slot entirely
            if (fall) begin
               state_d = WAIT_RISE;
            end else if (settle_q == SETTLE_LAST) begin
               state_d = GRANT;
               if (ext_cs != '0) begin
                  owner_d    = OWN_EXT;
                  sid_cs_d   = ext_cs;
                  sid_we_d   = ext_we;
                  sid_addr_d = ext_addr;
                  sid_data_d = ext_data;
                  if (host_valid)
                     starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 8'd1;
                  else
                     starve_d = '0;
               end else if (host_valid) begin
                  owner_d    = OWN_HOST;
                  sid_cs_d   = NUM_CS'(1) << host_sel;
                  sid_we_d   = host_we;
                  sid_addr_d = host_addr;
                  sid_data_d = host_data;
                  starve_d   = '0;
               end else begin
                  owner_d  = OWN_NONE;
                  starve_d = '0;
               end
            end else begin
               settle_d = settle_q + CNT_W'(1);
            end
         end
         GRANT: begin
            // sid_api commits on the fall; release the bus one clk later
            if (fall) begin
               state_d    = WAIT_RISE;
               owner_d    = OWN_NONE;
               sid_cs_d   = '0;
               sid_we_d   = 1'b0;
               sid_addr_d = '0;
               sid_data_d = '0;
               if (owner_q == OWN_HOST) begin
                  host_ready_d = 1'b1;
                  if (!sid_we_q) begin
                     host_rvalid_d = 1'b1;
                     host_rdata_d  = sid_rdata;
                  end
               end
            end
         end
         default: state_d = WAIT_RISE;
      endcase
      host_starved_d = (starve_d == STARVE_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= WAIT_RISE;
         owner_q        <= OWN_NONE;
         phi2_q         <= 1'b0;
         settle_q       <= '0;
         starve_q       <= '0;
         sid_cs_q       <= '0;
         sid_we_q       <= 1'b0;
         sid_addr_q     <= '0;
         sid_data_q     <= '0;
         host_ready_q   <= 1'b0;
         host_rvalid_q  <= 1'b0;
         host_rdata_q   <= '0;
         host_starved_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         phi2_q         <= phi2;
         settle_q       <= settle_d;
         starve_q       <= starve_d;
         sid_cs_q       <= sid_cs_d;
         sid_we_q       <= sid_we_d;
         sid_addr_q     <= sid_addr_d;
         sid_data_q     <= sid_data_d;
         host_ready_q   <= host_ready_d;
         host_rvalid_q  <= host_rvalid_d;
         host_rdata_q   <= host_rdata_d;
         host_starved_q <= host_starved_d;
      end
   end

   assign sid_cs       = sid_cs_q;
   assign sid_we       = sid_we_q;
   assign sid_addr     = sid_addr_q;
   assign sid_data     = sid_data_q;
   assign host_ready   = host_ready_q;
   assign host_rvalid  = host_rvalid_q;
   assign host_rdata   = host_rdata_q;
   assign host_starved = host_starved_q;

endmodule

// File: tb/tb_sid_bus_arbiter.sv
// Scoreboard bench for sid_bus_arbiter: per-slot expectations from a slot-level
// model, checked by an independent monitor on grants and host responses.
module tb_sid_bus_arbiter;

   localparam int SETTLE = 6;
   localparam int LIM    = 3;

   logic       clk = 0;
   logic       rst = 1;
   logic       phi2 = 0;
   logic [3:0] ext_cs = 0;
   logic       ext_we = 0;
   logic [4:0] ext_addr = 0;
   logic [7:0] ext_data = 0;
   logic       host_valid = 0;
   logic       host_ready;
   logic [1:0] host_sel = 0;
   logic       host_we = 0;
   logic [4:0] host_addr = 0;
   logic [7:0] host_data = 0;
   logic [7:0] host_rdata;
   logic       host_rvalid;
   logic       host_starved;
   logic [3:0] sid_cs;
   logic       sid_we;
   logic [4:0] sid_addr;
   logic [7:0] sid_data;
   logic [7:0] sid_rdata = 0;

   sid_bus_arbiter #(.SETTLE_CLKS(SETTLE), .STARVE_LIMIT(LIM), .NUM_CS(4)) dut (
      .clk(clk), .rst(rst), .phi2(phi2),
      .ext_cs(ext_cs), .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
      .host_valid(host_valid), .host_ready(host_ready), .host_sel(host_sel),
      .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
      .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_starved(host_starved),
      .sid_cs(sid_cs), .sid_we(sid_we), .sid_addr(sid_addr), .sid_data(sid_data),
      .sid_rdata(sid_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0] cs; logic we; logic [4:0] addr; logic [7:0] data;
      logic starved; int start; int stop;
   } gexp_t;
   typedef struct { int cyc; logic we; logic [7:0] rdata; } hexp_t;

   gexp_t gq[$];
   hexp_t hq[$];
   int checks = 0, failures = 0, hr_cnt = 0;
   int starve = 0;   // model of consecutive lost host slots

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      failures++;
      $display("FAIL %s: unexpected DUT activity at cyc %0d", name, cyc);
   endtask

   function automatic logic [3:0] onehot(input int i);
      logic [3:0] v;
      v = 4'b0001 << i;
      return v;
   endfunction

   // ---------------- monitor ----------------
   initial begin : mon
      bit    act = 0, unexp = 0, moved = 0;
      gexp_t g;
      hexp_t h;
      logic [17:0] held;
      forever begin
         @(negedge clk);
         if (!act && sid_cs != 0) begin
            act = 1; moved = 0;
            held = {sid_cs, sid_we, sid_addr, sid_data};
            if (gq.size() == 0) begin
               unexp = 1; flag("unexp_grant");
            end else begin
               unexp = 0;
               g = gq.pop_front();
               chk("grant_start", cyc, g.start);
               chk("grant_cs", sid_cs, g.cs);
               chk("grant_we", sid_we, g.we);
               chk("grant_addr", sid_addr, g.addr);
               chk("grant_data", sid_data, g.data);
               chk("starved", host_starved, g.starved);
            end
         end else if (act && sid_cs == 0) begin
            act = 0;
            if (!unexp) begin
               chk("grant_end", cyc, g.stop);
               chk("grant_stable", moved, 0);
               chk("release_zero", {sid_we, sid_addr, sid_data}, 0);
            end
         end else if (act && {sid_cs, sid_we, sid_addr, sid_data} != held) begin
            moved = 1;
         end
         if (host_ready) begin
            hr_cnt++;
            if (hq.size() == 0) flag("unexp_ready");
            else begin
               h = hq.pop_front();
               chk("ready_cyc", cyc, h.cyc);
               chk("rvalid", host_rvalid, !h.we);
               if (!h.we) chk("rdata", host_rdata, h.rdata);
            end
         end else if (host_rvalid) flag("rvalid_without_ready");
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (host_valid && host_ready) host_valid = 0;
   endtask

   task automatic host_req(input logic [1:0] sel, input logic we, input logic [4:0] a, input logic [7:0] d);
      host_valid = 1; host_sel = sel; host_we = we; host_addr = a; host_data = d;
   endtask

   // One phi2 cycle; the model decides the slot at the rise from the slot rules.
   task automatic run_slot(input int hi, input int lo, input logic [3:0] ecs, input logic ewe,
                           input logic [4:0] eaddr, input logic [7:0] edata, input bit late,
                           input logic [7:0] rd, input int rst_at);
      int n; bit pend; gexp_t g; hexp_t h;
      n = cyc; pend = host_valid;
      phi2 = 1; ext_cs = ecs;
      ext_we = (ecs != 0) ? ewe : 1'b0;
      ext_addr = (ecs != 0) ? eaddr : 5'd0;
      ext_data = (ecs != 0) ? edata : 8'd0;
      sid_rdata = rd;
      if (hi >= SETTLE + 1) begin
         g.start = n + SETTLE + 1;
         g.stop = (rst_at > 0) ? n + rst_at : n + hi + 1;
         if (ecs != 0) begin
            starve = pend ? ((starve + 1 > LIM) ? LIM : starve + 1) : 0;
            g.cs = ecs; g.we = ewe; g.addr = eaddr; g.data = edata;
            g.starved = (starve == LIM);
            gq.push_back(g);
         end else if (pend) begin
            starve = 0;
            g.cs = onehot(int'(host_sel)); g.we = host_we; g.addr = host_addr; g.data = host_data;
            g.starved = 0;
            gq.push_back(g);
            if (rst_at == 0) begin
               h.cyc = n + hi + 1; h.we = host_we; h.rdata = rd;
               hq.push_back(h);
            end
         end else starve = 0;
         if (rst_at > 0) starve = 0;
      end
      for (int i = 1; i <= hi; i++) begin
         tick();
         if (late && i == 8) begin
            ext_cs = onehot($urandom_range(0, 3));
            ext_we = 1'($urandom); ext_addr = 5'($urandom); ext_data = 8'($urandom);
         end
         if (rst_at == i) rst = 1;
      end
      phi2 = 0; ext_cs = 0; ext_we = 0; ext_addr = 0; ext_data = 0;
      for (int i = 1; i <= lo; i++) begin
         tick();
         if (i == 1) rst = 0;
      end
   endtask

   initial begin
      int hr0;
      // reset state
      rst = 1;
      repeat (3) tick();
      chk("rst_sid_cs", sid_cs, 0);
      chk("rst_sid_we", sid_we, 0);
      chk("rst_sid_addr", sid_addr, 0);
      chk("rst_sid_data", sid_data, 0);
      chk("rst_host_ready", host_ready, 0);
      chk("rst_host_rvalid", host_rvalid, 0);
      chk("rst_host_rdata", host_rdata, 0);
      chk("rst_host_starved", host_starved, 0);
      rst = 0;
      repeat (4) tick();

      // 1 MHz timing, host write
      host_req(2'd1, 1'b1, 5'h18, 8'h0F);
      run_slot(12, 12, 4'b0000, 0, 0, 0, 0, 8'h00, 0);
      // collision: ext wins, host next cycle
      host_req(2'd2, 1'b1, 5'h10, 8'h33);
      run_slot(12, 12, 4'b0001, 1'b1, 5'h04, 8'h41, 0, 8'h00, 0);
      chk("collision_host_pending", host_valid, 1);
      run_slot(12, 12, 4'b0000, 0, 0, 0, 0, 8'h00, 0);
      // host read
      host_req(2'd0, 1'b0, 5'h1B, 8'h00);
      run_slot(12, 12, 4'b0000, 0, 0, 0, 0, 8'hA5, 0);
      chk("read_rdata_hold", host_rdata, 8'hA5);
      // starvation
      host_req(2'd3, 1'b1, 5'h01, 8'h77);
      for (int k = 0; k < 3; k++)
         run_slot(12, 12, onehot(k), 1'b1, 5'(k), 8'(k + 8'h50), 0, 8'h00, 0);
      chk("starved_after_3", host_starved, 1);
      run_slot(12, 12, 4'b0000, 0, 0, 0, 0, 8'h00, 0);
      chk("starved_cleared", host_starved, 0);
      // reset mid-GRANT on a host slot, then served next cycle
      host_req(2'd2, 1'b0, 5'h0C, 8'h00);
      run_slot(12, 12, 4'b0000, 0, 0, 0, 0, 8'h3C, 9);
      chk("rst_host_still_pending", host_valid, 1);
      run_slot(12, 12, 4'b0000, 0, 0, 0, 0, 8'hC3, 0);
      // short phi2 high phase
      host_req(2'd1, 1'b1, 5'h05, 8'h99);
      hr0 = hr_cnt;
      run_slot(3, 12, 4'b0000, 0, 0, 0, 0, 8'h00, 0);
      chk("short_no_ready", hr_cnt, hr0);
      run_slot(12, 12, 4'b0000, 0, 0, 0, 0, 8'h00, 0);
      // ext_cs arriving after the decision point
      host_req(2'd3, 1'b0, 5'h1F, 8'h00);
      run_slot(12, 12, 4'b0000, 0, 0, 0, 1, 8'h5A, 0);
      // phi2 stopped
      host_req(2'd0, 1'b1, 5'h02, 8'hEE);
      hr0 = hr_cnt;
      repeat (40) tick();
      chk("stopped_no_ready", hr_cnt, hr0);
      run_slot(12, 12, 4'b0000, 0, 0, 0, 0, 8'h00, 0);

      // randomized slots
      for (int s = 0; s < 80; s++) begin
         int hi, lo; logic [3:0] ecs; bit late;
         if (!host_valid && $urandom_range(0, 9) < 6)
            host_req(2'($urandom), 1'($urandom), 5'($urandom), 8'($urandom));
         hi = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 5) : $urandom_range(7, 14);
         lo = $urandom_range(3, 12);
         ecs = ($urandom_range(0, 4) < 2) ? onehot($urandom_range(0, 3)) : 4'b0000;
         late = (ecs == 0) && (hi >= 9) && ($urandom_range(0, 4) == 0);
         run_slot(hi, lo, ecs, 1'($urandom), 5'($urandom), 8'($urandom), late, 8'($urandom), 0);
      end
      run_slot(12, 12, 4'b0000, 0, 0, 0, 0, 8'h00, 0);
      repeat (5) tick();
      chk("all_host_served", host_valid, 0);
      chk("grant_queue_empty", gq.size(), 0);
      chk("host_queue_empty", hq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
